// File: rtl/chacha_pkg.sv
// Shared ChaCha constants, state types, FSM encoding and quarter-round word table.
package chacha_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] SIGMA0 = 32'h61707865;
    localparam logic [WORD_W-1:0] SIGMA1 = 32'h3320646e;
    localparam logic [WORD_W-1:0] SIGMA2 = 32'h79622d32;
    localparam logic [WORD_W-1:0] SIGMA3 = 32'h6b206574;

    typedef logic [15:0][WORD_W-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } fsm_e;

    // Each entry packs the word indices {a,b,c,d} as nibbles, a in the top nibble.
    localparam logic [15:0] QR_TAB [8] = '{
        16'h048C, 16'h159D, 16'h26AE, 16'h37BF,
        16'h05AF, 16'h16BC, 16'h278D, 16'h349E
    };

    function automatic logic [3:0] qr_word(input logic [2:0] idx, input logic [1:0] pos);
        logic [15:0] entry;
        entry = QR_TAB[idx];
        return entry[{~pos, 2'b00} +: 4];
    endfunction

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter-round; every step consumes the previous step's result.
module chacha_qr
    import chacha_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [WORD_W-1:0] c,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] a_upd,
    output logic [WORD_W-1:0] b_upd,
    output logic [WORD_W-1:0] c_upd,
    output logic [WORD_W-1:0] d_upd
);

    logic [WORD_W-1:0] a1, b1, c1, d1;
    logic [WORD_W-1:0] a2, b2, c2, d2;

    always_comb begin
        a1 = a + b;
        d1 = rotl(d ^ a1, 16);
        c1 = c + d1;
        b1 = rotl(b ^ c1, 12);
        a2 = a1 + b1;
        d2 = rotl(d1 ^ a2, 8);
        c2 = c1 + d2;
        b2 = rotl(b1 ^ c2, 7);
    end

    assign a_upd = a2;
    assign b_upd = b2;
    assign c_upd = c2;
    assign d_upd = d2;

endmodule

// File: rtl/chacha_core_ctrl.sv
// Iterative ChaCha block core: one quarter-round per cycle, then a final feed-forward add.
// Optional feature macro: CHACHA_CTR_AUTOINC_EN (internal auto-incrementing block counter).
module chacha_core_ctrl
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  in_ctr,
`ifdef CHACHA_CTR_AUTOINC_EN
    input  logic         in_ctr_ld,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] keystream,
    output logic         busy
);

    localparam logic [4:0] DR_LAST = 5'(ROUNDS / 2 - 1);

    fsm_e        state, state_nxt;
    state_t      work, init, ks, init_load, work_nxt;
    logic [2:0]  qr_idx;
    logic [4:0]  dr_cnt;
    logic        accept, last_qr;
    logic [31:0] ctr_used;
    logic [3:0]  ia, ib, ic, id;
    logic [WORD_W-1:0] qa, qb, qc, qd;

    assign accept  = in_valid && (state == IDLE);
    assign last_qr = (qr_idx == 3'd7) && (dr_cnt == DR_LAST);

`ifdef CHACHA_CTR_AUTOINC_EN
    logic [31:0] ctr_reg;

    assign ctr_used = in_ctr_ld ? in_ctr : ctr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ctr_reg <= '0;
        else if (accept)
            ctr_reg <= ctr_used + 32'd1;
    end
`else
    assign ctr_used = in_ctr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (last_qr)
                    state_nxt = FINAL;
            end
            FINAL: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        init_load     = '0;
        init_load[0]  = SIGMA0;
        init_load[1]  = SIGMA1;
        init_load[2]  = SIGMA2;
        init_load[3]  = SIGMA3;
        for (int i = 0; i < 8; i++)
            init_load[4+i] = key[32*i +: 32];
        init_load[12] = ctr_used;
        for (int i = 0; i < 3; i++)
            init_load[13+i] = nonce[32*i +: 32];
    end

    assign ia = qr_word(qr_idx, 2'd0);
    assign ib = qr_word(qr_idx, 2'd1);
    assign ic = qr_word(qr_idx, 2'd2);
    assign id = qr_word(qr_idx, 2'd3);

    chacha_qr u_qr (
        .a     (work[ia]),
        .b     (work[ib]),
        .c     (work[ic]),
        .d     (work[id]),
        .a_upd (qa),
        .b_upd (qb),
        .c_upd (qc),
        .d_upd (qd)
    );

    always_comb begin
        work_nxt     = work;
        work_nxt[ia] = qa;
        work_nxt[ib] = qb;
        work_nxt[ic] = qc;
        work_nxt[id] = qd;
    end

    // Datapath registers follow the FSM; keystream only changes in FINAL so it holds after DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work   <= '0;
            init   <= '0;
            ks     <= '0;
            qr_idx <= '0;
            dr_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        work   <= init_load;
                        init   <= init_load;
                        qr_idx <= '0;
                        dr_cnt <= '0;
                    end
                end
                ROUND: begin
                    work   <= work_nxt;
                    qr_idx <= qr_idx + 3'd1;
                    if (qr_idx == 3'd7)
                        dr_cnt <= dr_cnt + 5'd1;
                end
                FINAL: begin
                    for (int i = 0; i < 16; i++)
                        ks[i] <= work[i] + init[i];
                end
                default: ;
            endcase
        end
    end

    assign keystream = ks;

endmodule

// File: tb/tb_chacha_core_ctrl.sv
// Scoreboard bench for chacha_core_ctrl with an independent ChaCha block reference model.
module tb_chacha_core_ctrl;

    localparam int ROUNDS = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  in_ctr;
`ifdef CHACHA_CTR_AUTOINC_EN
    logic         in_ctr_ld;
    logic [31:0]  ctr_model;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [511:0] keystream;
    logic         busy;

    logic [31:0]  qa, qb, qc, qd, qa_o, qb_o, qc_o, qd_o;

    logic [511:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chacha_core_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key       (key),
        .nonce     (nonce),
        .in_ctr    (in_ctr),
`ifdef CHACHA_CTR_AUTOINC_EN
        .in_ctr_ld (in_ctr_ld),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .keystream (keystream),
        .busy      (busy)
    );

    chacha_qr u_qr_tb (
        .a(qa), .b(qb), .c(qc), .d(qd),
        .a_upd(qa_o), .b_upd(qb_o), .c_upd(qc_o), .d_upd(qd_o)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] tb_qr(input logic [31:0] a, b, c, d);
        a = a + b; d = rol(d ^ a, 16);
        c = c + d; b = rol(b ^ c, 12);
        a = a + b; d = rol(d ^ a, 8);
        c = c + d; b = rol(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                               input logic [31:0] c);
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [511:0] r;
        logic [127:0] t;
        int ia, ib, ic, id, j;
        s[0] = 32'h61707865; s[1] = 32'h3320646e;
        s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
        x = s;
        for (int dr = 0; dr < ROUNDS / 2; dr++) begin
            for (int h = 0; h < 8; h++) begin
                j = h % 4;
                if (h < 4) begin
                    ia = j; ib = j + 4; ic = j + 8; id = j + 12;
                end else begin
                    ia = j; ib = 4 + (j + 1) % 4; ic = 8 + (j + 2) % 4; id = 12 + (j + 3) % 4;
                end
                t = tb_qr(x[ia], x[ib], x[ic], x[id]);
                {x[ia], x[ib], x[ic], x[id]} = t;
            end
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0)
                check("unexpected_block", {511'b0, out_valid}, 512'd0);
            else
                check("keystream", keystream, exp_q.pop_front());
        end
    end

    task automatic send(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                        input logic ld, input bit expect_out);
        logic [31:0] used;
`ifdef CHACHA_CTR_AUTOINC_EN
        used      = ld ? c : ctr_model;
        ctr_model = used + 32'd1;
        in_ctr_ld = ld;
`else
        used = c;
`endif
        key = k; nonce = n; in_ctr = c; in_valid = 1'b1;
        check("in_ready_at_req", {511'b0, in_ready}, 512'd1);
        if (expect_out) exp_q.push_back(ref_block(k, n, used));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_after_accept", {511'b0, busy}, 512'd1);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) check("out_valid_timeout", {511'b0, out_valid}, 512'd1);
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] key_rfc;
        logic [95:0]  nonce_rfc;
        logic [511:0] hold;
        int lat;

        for (int b = 0; b < 32; b++) key_rfc[8*b +: 8] = 8'(b);
        nonce_rfc = {32'h00000000, 32'h4a000000, 32'h09000000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        key = '0; nonce = '0; in_ctr = '0;
`ifdef CHACHA_CTR_AUTOINC_EN
        in_ctr_ld = 1'b0; ctr_model = '0;
`endif
        qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {511'b0, in_ready}, 512'd1);
        check("rst_out_valid", {511'b0, out_valid}, 512'd0);
        check("rst_busy", {511'b0, busy}, 512'd0);
        check("rst_keystream", keystream, 512'd0);
        check("qr_a", {480'b0, qa_o}, {480'b0, 32'hea2a92f4});
        check("qr_b", {480'b0, qb_o}, {480'b0, 32'hcb1cf8ce});
        check("qr_c", {480'b0, qc_o}, {480'b0, 32'h4581472e});
        check("qr_d", {480'b0, qd_o}, {480'b0, 32'h5881c4bb});
        rst = 1'b0;
        @(posedge clk); #1;

        // Reference vector and latency
        send(key_rfc, nonce_rfc, 32'd1, 1'b1, 1'b1);
        wait_out(lat);
        check("latency", lat, 4 * ROUNDS + 1);
        check("rfc_word0", {480'b0, keystream[31:0]}, {480'b0, 32'he4e7f110});
        check("rfc_word15", {480'b0, keystream[511:480]}, {480'b0, 32'h4e3c50a2});
        @(posedge clk); #1;
        check("idle_after_done", {511'b0, in_ready}, 512'd1);

        for (int t = 0; t < 3; t++) begin
            send(rand_key(), {$urandom, $urandom, $urandom}, $urandom, 1'b1, 1'b1);
            wait_out(lat);
            @(posedge clk); #1;
        end

        // Backpressure with ignored requests
        out_ready = 1'b0;
        send(rand_key(), {$urandom, $urandom, $urandom}, $urandom, 1'b1, 1'b1);
        wait_out(lat);
        hold = keystream;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_ctr = $urandom;
            check("bp_stable", keystream, hold);
            check("bp_in_ready", {511'b0, in_ready}, 512'd0);
            check("bp_out_valid", {511'b0, out_valid}, 512'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", {511'b0, in_ready}, 512'd1);
        check("bp_release_valid", {511'b0, out_valid}, 512'd0);
        check("ks_hold_after_done", keystream, hold);
        repeat (5) @(posedge clk);
        #1;
        check("no_queued_req", {511'b0, busy}, 512'd0);

        // Reset in the middle of ROUND
        send(key_rfc, nonce_rfc, 32'd1, 1'b1, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("midrst_busy", {511'b0, busy}, 512'd0);
        check("midrst_out_valid", {511'b0, out_valid}, 512'd0);
        check("midrst_keystream", keystream, 512'd0);
`ifdef CHACHA_CTR_AUTOINC_EN
        ctr_model = '0;
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("midrst_no_output", {511'b0, out_valid}, 512'd0);
        send(key_rfc, nonce_rfc, 32'd1, 1'b1, 1'b1);
        wait_out(lat);
        check("post_rst_word0", {480'b0, keystream[31:0]}, {480'b0, 32'he4e7f110});
        @(posedge clk); #1;

        // Counter load, wrap and back-to-back auto-increment
        send(rand_key(), {$urandom, $urandom, $urandom}, 32'hFFFFFFFF, 1'b1, 1'b1);
        wait_out(lat);
        @(posedge clk); #1;
        for (int t = 0; t < 3; t++) begin
            send(key_rfc, nonce_rfc, 32'h12345678 + 32'(t), 1'b0, 1'b1);
            wait_out(lat);
            @(posedge clk); #1;
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 512'(exp_q.size()), 512'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chacha_core_ctrl.md
CHACHA_CORE_CTRL -- requirements
Module: chacha_core_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 20, total ChaCha rounds; legal values are even and 2..20.
REQ-002 SHALL have ports clk (input, 1): single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst (input, 1): reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid (input, 1): block request present.
REQ-005 SHALL have port in_ready (output, 1): request accepted this cycle if in_valid is also high.
REQ-006 SHALL have port key (input, 256): key; word k at bits [32k+31:32k].
REQ-007 SHALL have port nonce (input, 96): nonce; word n at bits [32n+31:32n].
REQ-008 SHALL have port in_ctr (input, 32): block counter.
REQ-009 SHALL have port out_valid (output, 1): keystream block valid.
REQ-010 SHALL have port out_ready (input, 1): consumer accepts the block.
REQ-011 SHALL have port keystream (output, 512): result; state word i at bits [32i+31:32i].
REQ-012 SHALL have port busy (output, 1): high in ROUND or FINAL.

Function
REQ-013 SHALL implement FSM states IDLE, ROUND, FINAL, DONE.
REQ-014 SHALL drive in_ready high only in IDLE.
REQ-015 On an in_valid && in_ready edge, SHALL load both working and initial state: words 0..3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574; words 4..11 = key words 0..7; word 12 = counter; words 13..15 = nonce words 0..2. SHALL then go to ROUND with qr_idx = 0.
REQ-016 In ROUND, SHALL apply exactly one quarter-round per cycle.
REQ-017 The qr_idx to word mapping SHALL be: 0:(0,4,8,12), 1:(1,5,9,13), 2:(2,6,10,14), 3:(3,7,11,15), 4:(0,5,10,15), 5:(1,6,11,12), 6:(2,7,8,13), 7:(3,4,9,14).
REQ-018 qr_idx SHALL wrap from 7 to 0 and SHALL increment the double-round count on each wrap.
REQ-019 After 4*ROUNDS quarter-rounds, SHALL go to FINAL.
REQ-020 In FINAL, SHALL make keystream word i = working word i + initial word i, mod 2^32, in one cycle, then go to DONE.
REQ-021 Latency SHALL be 4*ROUNDS+1 cycles from the accepting edge to out_valid; this is 81 for ROUNDS=20.
REQ-022 In DONE, out_valid SHALL be high and keystream SHALL be held stable until out_ready is high.
REQ-023 On an out_valid && out_ready edge, SHALL go to IDLE.
REQ-024 in_valid while not in IDLE SHALL be ignored; the request is not queued.
REQ-025 keystream SHALL keep its last value after DONE exits, until the next FINAL.
REQ-026 All additions SHALL be 32-bit mod 2^32; rotates SHALL be circular left by 16, 12, 8, 7.

Reset
REQ-027 rst high SHALL immediately force: state IDLE, qr_idx 0, round count 0, out_valid 0, busy 0, in_ready 1 after release, keystream 0, and all state registers 0.
REQ-028 Reset mid-ROUND or in DONE SHALL discard the block without producing output.

Configuration
REQ-029 With macro CHACHA_CTR_AUTOINC_EN defined:
- SHALL add input in_ctr_ld (1 bit).
- SHALL keep an internal counter register, reset value 0.
- On acceptance with in_ctr_ld=1, the counter used SHALL be in_ctr.
- On acceptance with in_ctr_ld=0, the counter used SHALL be the stored value.
- The stored value SHALL become the used counter + 1, wrapping 0xFFFFFFFF -> 0x00000000.
REQ-030 Without CHACHA_CTR_AUTOINC_EN: in_ctr_ld SHALL be absent and in_ctr SHALL always be used.

Structure
REQ-031 Package chacha_pkg SHALL hold:
- the four sigma constants;
- word width 32;
- the state-word array typedef;
- the FSM state enum;
- the 8-entry quarter-round index table.
REQ-032 SHALL instantiate exactly one combinational sub-module, chacha_qr: inputs a, b, c, d; outputs a', b', c', d'. Each step SHALL use the updated value of the previous step.

Verification
REQ-033 chacha_qr standalone: a=11111111, b=01020304, c=9b8d6f43, d=01234567 -> a=ea2a92f4, b=cb1cf8ce, c=4581472e, d=5881c4bb.
REQ-034 Block test: key bytes 00..1f, nonce 000000090000004a00000000, in_ctr=1, ROUNDS=20 -> out_valid at 81 cycles; word0=0xe4e7f110, word15=0x4e3c50a2.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles -> keystream stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-036 Assert rst at ROUND cycle 40 -> out_valid stays 0; a fresh request after release gives the correct vector from REQ-034.
REQ-037 With CHACHA_CTR_AUTOINC_EN:
- load in_ctr=0xFFFFFFFF, then run a second request with in_ctr_ld=0 -> the second block uses counter 0.
- Back-to-back requests with in_ctr_ld=0 -> counter increments by 1 per block.
